// File: rtl/reg_file.sv
// Three-read, one-write architectural register file with hardwired-zero r0 and a committed-write counter.
// Optional write-first read bypass: define REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra0,
  output logic [WIDTH-1:0]  rd0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [WIDTH-1:0]  rd1,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] dbg_ra,
  output logic [WIDTH-1:0]  dbg_rd,
  output logic [15:0]       wr_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             commit;

  // Writes to r0 are discarded and never counted.
  assign commit = we && (wa != '0);

  // Storage and write counter; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_cnt <= '0;
    end else if (commit) begin
      regs[wa] <= wd;
      wr_cnt   <= wr_cnt + 16'd1;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = regs[a];
`ifdef REG_FILE_BYPASS_EN
    // Write-first: the in-flight write is forwarded, but never while reset holds the file at zero.
    if (commit && !rst && (a == wa)) begin
      v = wd;
    end
`endif
    if (a == '0) begin
      v = '0;
    end
    return v;
  endfunction

  assign rd0    = read_port(ra0);
  assign rd1    = read_port(ra1);
  assign dbg_rd = read_port(dbg_ra);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: array-based reference model compared every cycle, plus literal spot checks.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ra0, ra1, wa, dbg_ra;
  logic [31:0] rd0, rd1, wd, dbg_rd;
  logic        we;
  logic [15:0] wr_cnt;

  reg_file #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .ra0(ra0), .rd0(rd0),
    .ra1(ra1), .rd1(rd1),
    .we(we), .wa(wa), .wd(wd),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd),
    .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A write with an unknown address is a usage error of the register file.
  always @(posedge clk) begin
    if (we === 1'b1) assert (!$isunknown(wa)) else $error("unknown wa with we=1");
  end

  logic [31:0] m_regs [32];
  logic [15:0] m_cnt;
  int vectors  = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 16'h0;
  endtask

  // Architectural read rule: r0 and reset read zero; optional forwarding of a live write.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  // One clock cycle: compare all outputs mid-cycle, then commit to the model at the edge.
  task automatic step();
    @(negedge clk);
    chk("rd0", rd0, m_read(ra0));
    chk("rd1", rd1, m_read(ra1));
    chk("dbg_rd", dbg_rd, m_read(dbg_ra));
    chk("wr_cnt", {16'h0, wr_cnt}, {16'h0, m_cnt});
    @(posedge clk);
    if (!rst && we && wa != 5'd0) begin
      m_regs[wa] = wd;
      m_cnt      = m_cnt + 16'd1;
    end
    #1;
  endtask

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  dbg;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{5'd31, 32'hCAFE_F00D, 5'd5,  5'd31, 5'd0};
    tbl[1] = '{5'd1,  32'h0000_0001, 5'd31, 5'd1,  5'd31};
    tbl[2] = '{5'd31, 32'h8000_0000, 5'd31, 5'd31, 5'd31};
    tbl[3] = '{5'd16, 32'hA5A5_5A5A, 5'd16, 5'd5,  5'd16};
    tbl[4] = '{5'd0,  32'h1234_5678, 5'd0,  5'd0,  5'd0};
    tbl[5] = '{5'd5,  32'h0,         5'd5,  5'd16, 5'd5};

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra0 = '0; ra1 = '0; dbg_ra = '0;
    model_clear();
    #2;

    // Writes presented while reset is held must be ignored.
    we = 1'b1; wa = 5'd2; wd = 32'hAAAA_AAAA; ra0 = 5'd2;
    step();
    step();
    rst = 1'b0; we = 1'b0;

    for (int i = 0; i < 32; i++) begin
      dbg_ra = 5'(i);
      #1;
      chk("reset_dbg", dbg_rd, 32'h0);
    end
    chk("reset_cnt", {16'h0, wr_cnt}, 32'h0);

    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    step();
    we = 1'b0; ra0 = 5'd5; ra1 = 5'd5;
    #1;
    chk("dual_rd0", rd0, 32'hDEAD_BEEF);
    chk("dual_rd1", rd1, 32'hDEAD_BEEF);
    chk("dual_cnt", {16'h0, wr_cnt}, 32'd1);

    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra0 = 5'd0;
    step();
    we = 1'b0;
    #1;
    chk("r0_rd0", rd0, 32'h0);
    chk("r0_cnt", {16'h0, wr_cnt}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      we = 1'b1; wa = tbl[i].wa; wd = tbl[i].wd;
      ra0 = tbl[i].ra0; ra1 = tbl[i].ra1; dbg_ra = tbl[i].dbg;
      step();
    end
    we = 1'b0;
    step();

    we = 1'b1; wa = 5'd7; wd = 32'h11;
    step();
    we = 1'b1; wa = 5'd7; wd = 32'h22; ra0 = 5'd7;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("same_cycle_pre", rd0, 32'h22);
`else
    chk("same_cycle_pre", rd0, 32'h11);
`endif
    step();
    we = 1'b0;
    #1;
    chk("same_cycle_post", rd0, 32'h22);

    // Reset pulse landing between clock edges.
    we = 1'b1; wa = 5'd3; wd = 32'h1234;
    step();
    we = 1'b0; ra0 = 5'd3;
    #1;
    chk("pre_rst_rd0", rd0, 32'h1234);
    rst = 1'b1;
    #1;
    chk("async_rst_rd0", rd0, 32'h0);
    chk("async_rst_cnt", {16'h0, wr_cnt}, 32'h0);
    model_clear();
    we = 1'b1; wa = 5'd3; wd = 32'h5555;
    step();
    rst = 1'b0; we = 1'b0;
    #1;
    chk("rst_edge_lost", rd0, 32'h0);
    step();

    dbg_ra = 5'd1; ra0 = 5'd1; ra1 = 5'd0;
    for (int i = 0; i < 65536; i++) begin
      we = 1'b1; wa = 5'd1; wd = 32'(i);
      if (i == 65535) chk("cnt_before_wrap", {16'h0, wr_cnt}, 32'h0000_FFFF);
      step();
    end
    we = 1'b0;
    #1;
    chk("wrap_cnt", {16'h0, wr_cnt}, 32'h0);
    chk("wrap_r1", dbg_rd, 32'h0000_FFFF);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
